// File: rtl/iter_divide_if.sv
// iter_divide_if: request/result bundle for the iterative divider.
// The requester holds the master side, the divider the slave side.
interface iter_divide_if #(
  parameter int WIDTHN = 32,
  parameter int WIDTHD = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTHN-1:0] numer;
  logic [WIDTHD-1:0] denom;
  logic              n_signed;
  logic              d_signed;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTHN-1:0] quotient;
  logic [WIDTHD-1:0] remain;
  logic              div_by_zero;

  modport master (
    output in_valid, numer, denom,
    output n_signed, d_signed, out_ready,
    input  in_ready, out_valid,
    input  quotient, remain, div_by_zero
  );

  modport slave (
    input  in_valid, numer, denom,
    input  n_signed, d_signed, out_ready,
    output in_ready, out_valid,
    output quotient, remain, div_by_zero
  );
endinterface

// File: rtl/iter_divide.sv
// iter_divide: radix-2 restoring divider, one quotient bit per enabled
// cycle, with per-request signedness and an explicit divide-by-zero flag.
module iter_divide #(
  parameter int WIDTHN             = 32,
  parameter int WIDTHD             = 32,
  parameter bit REMAINDER_POSITIVE = 1'b1
) (
  input logic        clock,
  input logic        aclr,
  input logic        clken,
  iter_divide_if.slave bus
);
  localparam int CW = $clog2(WIDTHN);
  localparam int WX = (WIDTHN > WIDTHD) ? WIDTHN : WIDTHD;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t            state;
  state_t            next;
  logic [CW-1:0]     cnt;
  logic [WIDTHN-1:0] n_raw;
  logic [WIDTHD-1:0] d_raw;
  logic              n_sg;
  logic              d_sg;
  logic              sign_n;
  logic              sign_d;
  logic              dz;
  logic [WIDTHN-1:0] nq;
  logic [WIDTHD:0]   pr;
  logic [WIDTHD-1:0] dmag;
  logic [WIDTHN-1:0] q_out;
  logic [WIDTHD-1:0] r_out;
  logic              dz_out;

  logic              n_neg;
  logic              d_neg;
  logic [WIDTHD:0]   shifted;
  logic [WIDTHD+1:0] trial;
  logic              take;
  logic [WX-1:0]     n_ext;
  logic [WIDTHN-1:0] q_fix;
  logic [WIDTHD-1:0] r_fix;
  logic              r_neg;

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = q_out;
  assign bus.remain      = r_out;
  assign bus.div_by_zero = dz_out;

  assign n_neg   = n_sg & n_raw[WIDTHN-1];
  assign d_neg   = d_sg & d_raw[WIDTHD-1];
  assign shifted = {pr[WIDTHD-1:0], nq[WIDTHN-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dmag};
  assign take    = ~trial[WIDTHD+1];
  assign n_ext   = WX'(n_raw);

  // State register; clken freezes every state including DONE.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state <= IDLE;
    end else if (clken) begin
      state <= next;
    end
  end

  // Next-state decode.
  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (bus.in_valid) next = PREP;
      PREP: next = ITER;
      ITER: if (cnt == '0) next = FIX;
      FIX:  next = DONE;
      DONE: if (bus.out_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Sign fix-up of the magnitudes, remainder correction, zero override.
  always_comb begin
    q_fix = (sign_n ^ sign_d) ? -nq : nq;
    r_neg = sign_n && (pr[WIDTHD-1:0] != '0);
    r_fix = r_neg ? -pr[WIDTHD-1:0] : pr[WIDTHD-1:0];
    if (REMAINDER_POSITIVE && r_neg) begin
      r_fix = r_fix + dmag;
      q_fix = sign_d ? q_fix + WIDTHN'(1)
                     : q_fix - WIDTHN'(1);
    end
    if (dz) begin
      q_fix = '1;
      r_fix = n_ext[WIDTHD-1:0];
    end
  end

  // Capture, magnitude prep, bit-serial iteration and result registers.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      cnt    <= '0;
      n_raw  <= '0;
      d_raw  <= '0;
      n_sg   <= 1'b0;
      d_sg   <= 1'b0;
      sign_n <= 1'b0;
      sign_d <= 1'b0;
      dz     <= 1'b0;
      nq     <= '0;
      pr     <= '0;
      dmag   <= '0;
      q_out  <= '0;
      r_out  <= '0;
      dz_out <= 1'b0;
    end else if (clken) begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            n_raw <= bus.numer;
            d_raw <= bus.denom;
            n_sg  <= bus.n_signed;
            d_sg  <= bus.d_signed;
          end
        end
        PREP: begin
          nq     <= n_neg ? -n_raw : n_raw;
          dmag   <= d_neg ? -d_raw : d_raw;
          sign_n <= n_neg;
          sign_d <= d_neg;
          dz     <= (d_raw == '0);
          pr     <= '0;
          cnt    <= CW'(WIDTHN - 1);
        end
        ITER: begin
          pr <= take ? trial[WIDTHD:0] : shifted;
          nq <= {nq[WIDTHN-2:0], take};
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIX: begin
          q_out  <= q_fix;
          r_out  <= r_fix;
          dz_out <= dz;
        end
        DONE: ;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_divide.sv
// tb_iter_divide: directed checks of two 8-bit dividers, one per
// remainder mode, driven with identical stimulus.
module tb_iter_divide;
  logic       clock = 1'b0;
  logic       aclr = 1'b1;
  logic       clken = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       n_signed = 1'b0;
  logic       d_signed = 1'b0;
  logic [7:0] numer = '0;
  logic [7:0] denom = '0;
  int         checks = 0;
  int         errors = 0;
  int         lat;
  int         dis;
  logic       ir_bad;
  logic       stable;
  logic       ov_seen;
  logic [7:0] q0;
  logic [7:0] r0;

  iter_divide_if #(.WIDTHN(8), .WIDTHD(8)) bp ();
  iter_divide_if #(.WIDTHN(8), .WIDTHD(8)) bn ();

  assign bp.in_valid  = in_valid;
  assign bp.numer     = numer;
  assign bp.denom     = denom;
  assign bp.n_signed  = n_signed;
  assign bp.d_signed  = d_signed;
  assign bp.out_ready = out_ready;
  assign bn.in_valid  = in_valid;
  assign bn.numer     = numer;
  assign bn.denom     = denom;
  assign bn.n_signed  = n_signed;
  assign bn.d_signed  = d_signed;
  assign bn.out_ready = out_ready;

  iter_divide #(
    .WIDTHN(8), .WIDTHD(8), .REMAINDER_POSITIVE(1'b1)
  ) u_pos (
    .clock(clock), .aclr(aclr), .clken(clken), .bus(bp)
  );

  iter_divide #(
    .WIDTHN(8), .WIDTHD(8), .REMAINDER_POSITIVE(1'b0)
  ) u_neg (
    .clock(clock), .aclr(aclr), .clken(clken), .bus(bn)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] n, input logic [7:0] d,
                      input logic ns, input logic ds);
    int k;
    k = 0;
    clken = 1'b1;
    numer = n;
    denom = d;
    n_signed = ns;
    d_signed = ds;
    in_valid = 1'b1;
    while (!bp.in_ready && k < 50) begin
      @(posedge clock); #1;
      k++;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    numer = ~n;
    denom = ~d;
    n_signed = ~ns;
    d_signed = ~ds;
  endtask

  task automatic wait_done(input logic [15:0] pat);
    lat = 0;
    dis = 0;
    ir_bad = 1'b0;
    while (!bp.out_valid && lat < 200) begin
      clken = (lat < 16) ? ~pat[lat] : 1'b1;
      @(posedge clock); #1;
      lat++;
      if (!clken) dis++;
      if (bp.in_ready) ir_bad = 1'b1;
    end
    clken = 1'b1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 aclr = 1'b0;
    chk("rst_in_ready", bp.in_ready, 1);
    chk("rst_out_valid", bp.out_valid, 0);
    chk("rst_quotient", bp.quotient, 0);
    chk("rst_remain", bp.remain, 0);
    chk("rst_dbz", bp.div_by_zero, 0);

    send(8'd100, 8'd7, 1'b0, 1'b0);
    wait_done(16'h0000);
    chk("u100_7_lat", lat, 10);
    chk("u100_7_q", bp.quotient, 8'd14);
    chk("u100_7_r", bp.remain, 8'd2);
    chk("u100_7_dbz", bp.div_by_zero, 0);
    chk("u100_7_q_rp0", bn.quotient, 8'd14);
    chk("u100_7_r_rp0", bn.remain, 8'd2);
    consume();
    chk("u100_7_ready_after", bp.in_ready, 1);
    chk("u100_7_valid_after", bp.out_valid, 0);

    send(8'hF9, 8'h02, 1'b1, 1'b1);
    wait_done(16'h0000);
    chk("sm7_2_q_rp1", bp.quotient, 8'hFC);
    chk("sm7_2_r_rp1", bp.remain, 8'h01);
    chk("sm7_2_q_rp0", bn.quotient, 8'hFD);
    chk("sm7_2_r_rp0", bn.remain, 8'hFF);
    consume();

    send(8'h07, 8'hFE, 1'b1, 1'b1);
    wait_done(16'h0000);
    chk("s7_m2_q_rp1", bp.quotient, 8'hFD);
    chk("s7_m2_r_rp1", bp.remain, 8'h01);
    chk("s7_m2_q_rp0", bn.quotient, 8'hFD);
    chk("s7_m2_r_rp0", bn.remain, 8'h01);
    consume();

    send(8'h80, 8'hFF, 1'b1, 1'b1);
    wait_done(16'h0000);
    chk("sm128_m1_q", bp.quotient, 8'h80);
    chk("sm128_m1_r", bp.remain, 8'h00);
    chk("sm128_m1_q_rp0", bn.quotient, 8'h80);
    consume();

    send(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(16'h0000);
    chk("uFF_1_q", bp.quotient, 8'hFF);
    chk("uFF_1_r", bp.remain, 8'h00);
    consume();

    send(8'h5A, 8'h00, 1'b0, 1'b0);
    wait_done(16'h0000);
    chk("dz_lat", lat, 10);
    chk("dz_q", bp.quotient, 8'hFF);
    chk("dz_r", bp.remain, 8'h5A);
    chk("dz_flag", bp.div_by_zero, 1);
    chk("dz_flag_rp0", bn.div_by_zero, 1);
    consume();

    send(8'd9, 8'd3, 1'b0, 1'b0);
    wait_done(16'h0000);
    chk("u9_3_q", bp.quotient, 8'd3);
    chk("u9_3_r", bp.remain, 8'd0);
    chk("u9_3_dbz", bp.div_by_zero, 0);
    consume();

    send(8'd200, 8'd9, 1'b0, 1'b0);
    wait_done(16'b0000_0001_0010_1000);
    chk("stall_dis", dis, 3);
    chk("stall_lat", lat, 13);
    chk("stall_ready_low", ir_bad, 0);
    chk("stall_q", bp.quotient, 8'd22);
    chk("stall_r", bp.remain, 8'd2);
    q0 = bp.quotient;
    r0 = bp.remain;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      clken = (i % 3 != 1);
      @(posedge clock); #1;
      if (bp.quotient !== q0 || bp.remain !== r0 ||
          bp.out_valid !== 1'b1 || bp.in_ready !== 1'b0)
        stable = 1'b0;
    end
    clken = 1'b1;
    chk("hold_stable", stable, 1);
    consume();
    chk("hold_ready_after", bp.in_ready, 1);

    send(8'd50, 8'd7, 1'b0, 1'b0);
    repeat (4) @(posedge clock);
    #3 aclr = 1'b1;
    #1;
    chk("arst_in_ready", bp.in_ready, 1);
    chk("arst_out_valid", bp.out_valid, 0);
    chk("arst_quotient", bp.quotient, 0);
    chk("arst_remain", bp.remain, 0);
    chk("arst_dbz", bp.div_by_zero, 0);
    chk("arst_quotient_rp0", bn.quotient, 0);
    @(posedge clock); #1;
    aclr = 1'b0;
    ov_seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clock); #1;
      if (bp.out_valid || bn.out_valid) ov_seen = 1'b1;
    end
    chk("arst_no_valid", ov_seen, 0);

    send(8'd50, 8'd7, 1'b0, 1'b0);
    wait_done(16'h0000);
    chk("post_rst_lat", lat, 10);
    chk("post_rst_q", bp.quotient, 8'd7);
    chk("post_rst_r", bp.remain, 8'd1);
    consume();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/iter_divide.md
# iter_divide

Multi-cycle, handshaked integer divider and the sequential successor to the combinational/pipelined `lpm_divide`. It computes `denom * quotient + remain = numer` for parametrised operand widths, using a radix-2 restoring iteration with one quotient bit per cycle. Signedness is selectable per operation, and divide-by-zero is flagged explicitly. It serves the geometry and rasterizer datapaths where area matters more than throughput; the full-width array divider is too large there.

## Interface
- `WIDTHN`, 32: width of `numer` and `quotient`; must be ≥ 2.
- `WIDTHD`, 32: width of `denom` and `remain`; must be ≥ 2.
- `REMAINDER_POSITIVE`, 1: 1 = remainder is always ≥ 0; 0 = remainder is zero or has the sign of the numerator.
- `clock` in 1: the single clock; all state updates on its rising edge.
- `aclr` in 1: reset, asynchronous and active-high.
- `clken` in 1: clock enable; when 0, all state, including handshakes, is frozen.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `numer` in WIDTHN: numerator.
- `denom` in WIDTHD: denominator.
- `n_signed` in 1: numerator is two's complement, sampled with the request.
- `d_signed` in 1: denominator is two's complement, sampled with the request.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `quotient` out WIDTHN: quotient.
- `remain` out WIDTHD: remainder.
- `div_by_zero` out 1: the result belongs to a request with `denom == 0`.

## Operation
- A request is accepted on a `clock` edge with `clken & in_valid & in_ready`. All inputs are captured at that edge and may change afterwards.
- A result is consumed on a `clock` edge with `clken & out_valid & out_ready`.
- State machine:
  - `IDLE`: `in_ready` = 1. On accept, go to `PREP`.
  - `PREP` (1 cycle): take magnitudes. A negative operand is negated only if its `*_signed` bit is set. Record `sign_n`, `sign_d` and the zero-denominator condition. Load the iteration counter with `WIDTHN-1`. Go to `ITER`.
  - `ITER` (exactly `WIDTHN` cycles): each cycle, shift the next numerator bit (MSB first) into a `WIDTHD+1`-bit partial remainder. Trial-subtract `|denom|`. If the result is non-negative, keep it and set the quotient bit to 1; otherwise set the bit to 0. After the counter reaches 0, go to `FIX`.
  - `FIX` (1 cycle): apply signs.
    - `q = sign_n^sign_d ? -qmag : qmag`.
    - `r = (rmag != 0 && sign_n) ? -rmag : rmag`.
    - If `REMAINDER_POSITIVE` and `r < 0`: `r += |denom|`, and `q += sign_d ? +1 : -1`.
    - Register the results and set `out_valid`. Go to `DONE`.
  - `DONE`: hold the outputs stable. On consume, clear `out_valid` and go to `IDLE`.
- Division truncates toward zero before the optional remainder correction.
- All arithmetic is modulo 2^WIDTHN for the quotient and 2^WIDTHD for the remainder. The signed case -2^(WIDTHN-1) / -1 yields quotient 0x80…0 and remain 0; no overflow flag is raised.
- Divide-by-zero: the iteration still runs, so latency is unchanged. The result is overridden in `FIX`:
  - `quotient` = all ones.
  - `remain` = captured `numer`, truncated or zero-extended to WIDTHD.
  - `div_by_zero` = 1.
  - Otherwise `div_by_zero` = 0.
- Only one operation is in flight at a time. `in_ready` is 0 in every state except `IDLE`.

## Timing
- Reset (asynchronous, `aclr` = 1): state goes to `IDLE`.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `quotient` = 0, `remain` = 0, `div_by_zero` = 0.
  - Iteration counter = 0.
- `aclr` asserted mid-operation discards the in-flight operation immediately. No partial result is ever presented.
- Latency: `out_valid` rises `WIDTHN+2` enabled edges after the accept edge (1 for `PREP`, `WIDTHN` for `ITER`, 1 for `FIX`).
- If the result is consumed on the first `DONE` edge, `in_ready` is 1 on the following cycle. Minimum initiation interval is `WIDTHN+4` enabled cycles.
- `clken` = 0 stalls every state, including `DONE`. Latency is counted in enabled edges only.
- Outputs are registered and have no combinational path from any input. `in_ready` and `out_valid` depend only on state.
- `in_valid` asserted while `in_ready` = 0 has no effect. Requesters must hold the request until accepted.

## Test plan
- Unsigned 8-bit (WIDTHN = WIDTHD = 8), 100/7: quotient 14, remain 2, `div_by_zero` 0. `out_valid` rises exactly 10 edges after accept.
- Signed -7/2: with REMAINDER_POSITIVE=1, quotient -4 (0xFC), remain 1. With REMAINDER_POSITIVE=0, quotient -3 (0xFD), remain -1 (0xFF). The case 7/-2 with REMAINDER_POSITIVE=1 gives quotient -3, remain 1.
- 8-bit signed -128/-1: quotient 0x80, remain 0. Unsigned 0xFF/0x01: quotient 0xFF, remain 0.
- `denom` = 0, `numer` = 0x5A: quotient 0xFF, remain 0x5A, `div_by_zero` 1, latency still 10. The next request, 9/3, clears the flag.
- Hold `out_ready` = 0 for 20 cycles and toggle `clken` during `ITER`: outputs stay stable and `in_ready` stays 0. Latency stretches by exactly the number of disabled edges.
- Assert `aclr` in the 4th `ITER` cycle: all outputs return to their reset values asynchronously and `out_valid` never pulses. A fresh request afterwards produces a correct result.
